// File: rtl/ysyx_25040111_rr_arbiter_if.sv
// Request/response bundle between the requesting masters, the arbiter and the LSU port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface ysyx_25040111_rr_arbiter_if #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    logic [NUM_M-1:0]        m_req_valid;
    logic [NUM_M-1:0]        m_req_ready;
    logic [NUM_M-1:0]        m_req_write;
    logic [NUM_M*ADDR_W-1:0] m_req_addr;
    logic [NUM_M*DATA_W-1:0] m_req_wdata;
    logic [NUM_M*2-1:0]      m_req_mask;
    logic [NUM_M-1:0]        m_req_sign;
    logic [NUM_M*LEN_W-1:0]  m_req_len;
    logic [NUM_M-1:0]        m_resp_valid;
    logic [NUM_M-1:0]        m_resp_last;
    logic [DATA_W-1:0]       m_resp_data;

    logic                    s_req_valid;
    logic                    s_req_ready;
    logic                    s_req_write;
    logic [ADDR_W-1:0]       s_req_addr;
    logic [DATA_W-1:0]       s_req_wdata;
    logic [1:0]              s_req_mask;
    logic                    s_req_sign;
    logic [LEN_W-1:0]        s_req_len;
    logic                    s_resp_valid;
    logic                    s_resp_last;
    logic [DATA_W-1:0]       s_resp_data;

    modport slave (
        input  m_req_valid, m_req_write, m_req_addr, m_req_wdata, m_req_mask, m_req_sign, m_req_len,
        output m_req_ready, m_resp_valid, m_resp_last, m_resp_data,
        output s_req_valid, s_req_write, s_req_addr, s_req_wdata, s_req_mask, s_req_sign, s_req_len,
        input  s_req_ready, s_resp_valid, s_resp_last, s_resp_data
    );

    modport master (
        output m_req_valid, m_req_write, m_req_addr, m_req_wdata, m_req_mask, m_req_sign, m_req_len,
        input  m_req_ready, m_resp_valid, m_resp_last, m_resp_data,
        input  s_req_valid, s_req_write, s_req_addr, s_req_wdata, s_req_mask, s_req_sign, s_req_len,
        output s_req_ready, s_resp_valid, s_resp_last, s_resp_data
    );
endinterface

// File: rtl/ysyx_25040111_rr_arbiter.sv
// N-master transaction arbiter in front of the single LSU port, with burst beat-count checking.
// Define YSYX_25040111_RR_ARB_EN for round-robin arbitration; otherwise the lowest index wins.
module ysyx_25040111_rr_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    ysyx_25040111_rr_arbiter_if.slave  bus,
    output logic [$clog2(NUM_M)-1:0]   grant,
    output logic                       busy,
    output logic                       proto_err
);
    localparam int GW = $clog2(NUM_M);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, win;
    logic [LEN_W-1:0]  len_q, beat_cnt;
    logic              any_req, req_fire, last_beat;

    logic [ADDR_W-1:0] addr_a  [NUM_M];
    logic [DATA_W-1:0] wdata_a [NUM_M];
    logic [1:0]        mask_a  [NUM_M];
    logic [LEN_W-1:0]  len_a   [NUM_M];

    always_comb begin
        for (int i = 0; i < NUM_M; i++) begin
            addr_a[i]  = bus.m_req_addr[i*ADDR_W +: ADDR_W];
            wdata_a[i] = bus.m_req_wdata[i*DATA_W +: DATA_W];
            mask_a[i]  = bus.m_req_mask[i*2 +: 2];
            len_a[i]   = bus.m_req_len[i*LEN_W +: LEN_W];
        end
    end

    assign any_req   = |bus.m_req_valid;
    assign req_fire  = (state_q == REQ) && bus.s_req_ready;
    assign last_beat = (beat_cnt == len_q);

`ifdef YSYX_25040111_RR_ARB_EN
    logic [GW-1:0] ptr_q;

    // Winner is the requester closest to ptr_q going upward, wrapping at NUM_M.
    always_comb begin
        int best;
        int dist;
        best = NUM_M;
        dist = 0;
        win  = '0;
        for (int i = 0; i < NUM_M; i++) begin
            dist = (i + NUM_M - int'(ptr_q)) % NUM_M;
            if (bus.m_req_valid[i] && (dist < best)) begin
                best = dist;
                win  = GW'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if ((state_q == IDLE) && any_req) begin
            ptr_q <= (win == GW'(NUM_M - 1)) ? '0 : win + GW'(1);
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (bus.m_req_valid[i]) win = GW'(i);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = REQ;
            REQ:     if (bus.s_req_ready) state_d = RESP;
            RESP:    if (bus.s_resp_valid && (last_beat || bus.s_resp_last)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            beat_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && any_req) grant_q <= win;
            if (req_fire) begin
                beat_cnt <= '0;
            end else if ((state_q == RESP) && bus.s_resp_valid) begin
                beat_cnt <= beat_cnt + LEN_W'(1);
            end
            if ((state_q == RESP) && bus.s_resp_valid && (bus.s_resp_last != last_beat)) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Writes always carry a single beat, whatever their len field says.
    always_ff @(posedge clock) begin
        if ((state_q == IDLE) && any_req) begin
            len_q <= bus.m_req_write[win] ? '0 : len_a[win];
        end
    end

    always_comb begin
        bus.m_req_ready  = '0;
        bus.m_resp_valid = '0;
        bus.m_resp_last  = '0;
        bus.m_resp_data  = '0;
        bus.s_req_valid  = 1'b0;
        bus.s_req_write  = 1'b0;
        bus.s_req_addr   = '0;
        bus.s_req_wdata  = '0;
        bus.s_req_mask   = '0;
        bus.s_req_sign   = 1'b0;
        bus.s_req_len    = '0;
        if (state_q == REQ) begin
            bus.s_req_valid = 1'b1;
            bus.s_req_write = bus.m_req_write[grant_q];
            bus.s_req_addr  = addr_a[grant_q];
            bus.s_req_wdata = wdata_a[grant_q];
            bus.s_req_mask  = mask_a[grant_q];
            bus.s_req_sign  = bus.m_req_sign[grant_q];
            bus.s_req_len   = bus.m_req_write[grant_q] ? '0 : len_a[grant_q];
            bus.m_req_ready[grant_q] = bus.s_req_ready;
        end
        if (state_q == RESP) begin
            bus.m_resp_valid[grant_q] = bus.s_resp_valid;
            bus.m_resp_last[grant_q]  = bus.s_resp_valid & last_beat;
            bus.m_resp_data           = bus.s_resp_data;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_ysyx_25040111_rr_arbiter.sv
// Self-checking bench for ysyx_25040111_rr_arbiter: directed scenarios plus random transactions
// checked against a transaction-level model of grant order, beat framing and the error flag.
module tb_ysyx_25040111_rr_arbiter;
    localparam int NUM_M  = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int GW     = $clog2(NUM_M);
    localparam int RW     = 5 + LEN_W + ADDR_W + DATA_W;
    localparam int OW     = 3*NUM_M + DATA_W + RW + 2 + GW;

    logic          clock = 1'b0;
    logic          reset;
    logic [GW-1:0] grant;
    logic          busy;
    logic          proto_err;

    ysyx_25040111_rr_arbiter_if #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus();

    ysyx_25040111_rr_arbiter #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .grant(grant), .busy(busy), .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Model state: index of the most recent grant and the expected sticky error flag.
    int   last_grant;
    logic model_perr;

    logic [ADDR_W-1:0] m_addr  [NUM_M];
    logic [DATA_W-1:0] m_wdata [NUM_M];
    logic [1:0]        m_mask  [NUM_M];
    logic              m_sign  [NUM_M];
    logic              m_write [NUM_M];
    logic [LEN_W-1:0]  m_len   [NUM_M];

    function automatic int model_pick(input logic [NUM_M-1:0] r);
`ifdef YSYX_25040111_RR_ARB_EN
        for (int k = 1; k <= NUM_M; k++) begin
            if (r[(last_grant + k) % NUM_M]) return (last_grant + k) % NUM_M;
        end
`else
        for (int i = 0; i < NUM_M; i++) begin
            if (r[i]) return i;
        end
`endif
        return 0;
    endfunction

    function automatic logic [OW-1:0] all_outs();
        return {bus.m_resp_valid, bus.m_resp_last, bus.m_resp_data, bus.m_req_ready,
                bus.s_req_valid, bus.s_req_write, bus.s_req_sign, bus.s_req_mask, bus.s_req_len,
                bus.s_req_addr, bus.s_req_wdata, busy, proto_err, grant};
    endfunction

    task automatic drive_fields();
        for (int i = 0; i < NUM_M; i++) begin
            bus.m_req_addr[i*ADDR_W +: ADDR_W]  = m_addr[i];
            bus.m_req_wdata[i*DATA_W +: DATA_W] = m_wdata[i];
            bus.m_req_mask[i*2 +: 2]            = m_mask[i];
            bus.m_req_len[i*LEN_W +: LEN_W]     = m_len[i];
            bus.m_req_sign[i]                   = m_sign[i];
            bus.m_req_write[i]                  = m_write[i];
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NUM_M; i++) begin
            m_addr[i] = '0; m_wdata[i] = '0; m_mask[i] = '0;
            m_sign[i] = 1'b0; m_write[i] = 1'b0; m_len[i] = '0;
        end
        drive_fields();
        bus.m_req_valid  = '0;
        bus.s_req_ready  = 1'b0;
        bus.s_resp_valid = 1'b0;
        bus.s_resp_last  = 1'b0;
        bus.s_resp_data  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        @(negedge clock);
        @(negedge clock);
        reset      = 1'b0;
        last_grant = NUM_M - 1;
        model_perr = 1'b0;
    endtask

    // One full transaction starting from IDLE at a negedge. last_at < 0 means the LSU frames
    // the burst correctly; abort_at >= 0 asserts reset in place of that beat.
    task automatic run_txn(input logic [NUM_M-1:0] reqs, input bit keep, input int rdy_dly,
                           input int last_at_in, input int abort_at,
                           input logic [DATA_W-1:0] dbase, output int obs);
        int               w, len_eff, last_at, b;
        bit               done;
        logic [NUM_M-1:0] exp_one;
        logic [DATA_W-1:0] d;
        logic [RW-1:0]    exp_req, got_req;
        obs = -1;
        drive_fields();
        bus.m_req_valid = reqs;
        w = model_pick(reqs);
        exp_one = NUM_M'(1) << w;
        len_eff = m_write[w] ? 0 : int'(m_len[w]);
        last_at = (last_at_in < 0) ? len_eff : last_at_in;
        #1;
        checks++;
        if (busy !== 1'b0 || bus.s_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_state busy=%b s_req_valid=%b required 0 0", busy, bus.s_req_valid);
        end
        @(negedge clock);
        last_grant = w;
        obs = int'(grant);
        checks++;
        if (grant !== GW'(w)) begin
            errors++;
            $display("FAIL grant got=%0d required=%0d", grant, w);
        end
        exp_req = {1'b1, m_write[w], m_sign[w], m_mask[w], LEN_W'(len_eff), m_addr[w], m_wdata[w]};
        got_req = {bus.s_req_valid, bus.s_req_write, bus.s_req_sign, bus.s_req_mask, bus.s_req_len,
                   bus.s_req_addr, bus.s_req_wdata};
        checks++;
        if (got_req !== exp_req) begin
            errors++;
            $display("FAIL s_req_fields got=%h required=%h", got_req, exp_req);
        end
        for (int i = 0; i < rdy_dly; i++) begin
            bus.s_req_ready = 1'b0;
            #1;
            checks++;
            if (bus.m_req_ready !== '0 || bus.s_req_valid !== 1'b1) begin
                errors++;
                $display("FAIL req_wait m_req_ready=%b s_req_valid=%b required 0 1", bus.m_req_ready, bus.s_req_valid);
            end
            @(negedge clock);
        end
        bus.s_req_ready = 1'b1;
        #1;
        checks++;
        if (bus.m_req_ready !== exp_one) begin
            errors++;
            $display("FAIL m_req_ready got=%b required=%b", bus.m_req_ready, exp_one);
        end
        @(negedge clock);
        bus.s_req_ready = 1'b0;
        if (!keep) bus.m_req_valid = bus.m_req_valid & ~exp_one;
        done = 1'b0;
        for (b = 0; !done; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.s_resp_valid = 1'b0;
                #1;
                checks++;
                if (bus.m_resp_valid !== '0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL resp_gap m_resp_valid=%b busy=%b required 0 1", bus.m_resp_valid, busy);
                end
                @(negedge clock);
            end
            d = (dbase == '0) ? DATA_W'($urandom) : dbase + DATA_W'(b);
            bus.s_resp_valid = 1'b1;
            bus.s_resp_data  = d;
            bus.s_resp_last  = (b == last_at);
            if (b == abort_at) begin
                reset = 1'b1;
                #1;
                checks++;
                if (all_outs() !== '0) begin
                    errors++;
                    $display("FAIL reset_abort outputs=%h required 0", all_outs());
                end
                clear_inputs();
                last_grant = NUM_M - 1;
                model_perr = 1'b0;
                @(negedge clock);
                reset = 1'b0;
                return;
            end
            #1;
            checks++;
            if (bus.m_resp_valid !== exp_one || bus.m_resp_data !== d ||
                bus.m_resp_last !== ((b == len_eff) ? exp_one : '0)) begin
                errors++;
                $display("FAIL resp_beat%0d valid=%b last=%b data=%h required %b %b %h", b,
                         bus.m_resp_valid, bus.m_resp_last, bus.m_resp_data,
                         exp_one, (b == len_eff) ? exp_one : '0, d);
            end
            if ((b == last_at) != (b == len_eff)) model_perr = 1'b1;
            done = (b == len_eff) || (b == last_at);
            @(negedge clock);
            bus.s_resp_valid = 1'b0;
            bus.s_resp_last  = 1'b0;
        end
        #1;
        checks++;
        if (busy !== 1'b0 || proto_err !== model_perr) begin
            errors++;
            $display("FAIL txn_end busy=%b proto_err=%b required 0 %b", busy, proto_err, model_perr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        @(negedge clock);
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_held outputs=%h required 0", all_outs());
        end
        reset      = 1'b0;
        last_grant = NUM_M - 1;
        model_perr = 1'b0;
        @(negedge clock);
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_released outputs=%h required 0", all_outs());
        end
    endtask

    task automatic test_single_read();
        int g;
        clear_inputs();
        m_addr[1] = 32'h8000_0010;
        m_mask[1] = 2'd2;
        run_txn(NUM_M'(2), 1'b0, 0, -1, -1, 32'hDEAD_BEEF, g);
        checks++;
        if (g != 1) begin
            errors++;
            $display("FAIL single_read_grant got=%0d required=1", g);
        end
    endtask

    task automatic test_burst_read();
        int g;
        clear_inputs();
        m_addr[0] = 32'h8000_0100;
        m_mask[0] = 2'd2;
        m_len[0]  = 8'd3;
        run_txn(NUM_M'(1), 1'b0, 1, -1, -1, 32'h1, g);
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL burst_proto_err got=%b required=0", proto_err);
        end
    endtask

    task automatic test_arbitration();
        int g;
        int want;
        do_reset();
        m_addr[0] = 32'h1000;
        m_addr[1] = 32'h2000;
        for (int i = 0; i < 6; i++) begin
            run_txn(NUM_M'(3), 1'b1, 0, -1, -1, '0, g);
`ifdef YSYX_25040111_RR_ARB_EN
            want = i % 2;
`else
            want = 0;
`endif
            checks++;
            if (g != want) begin
                errors++;
                $display("FAIL arb_seq%0d grant=%0d required=%0d", i, g, want);
            end
        end
        clear_inputs();
    endtask

    task automatic test_write();
        int g;
        clear_inputs();
        m_write[1] = 1'b1;
        m_addr[1]  = 32'h8000_0200;
        m_wdata[1] = 32'h1234_5678;
        m_mask[1]  = 2'd2;
        m_len[1]   = 8'd5;
        run_txn(NUM_M'(2), 1'b0, 0, -1, -1, '0, g);
        checks++;
        if (g != 1) begin
            errors++;
            $display("FAIL write_grant got=%0d required=1", g);
        end
    endtask

    task automatic test_len_mismatch();
        int g;
        clear_inputs();
        m_len[0] = 8'd1;
        run_txn(NUM_M'(1), 1'b0, 0, 0, -1, '0, g);
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_flag got=%b required=1", proto_err);
        end
        m_len[0] = 8'd2;
        run_txn(NUM_M'(1), 1'b0, 0, -1, -1, '0, g);
    endtask

    task automatic test_reset_mid_burst();
        int g;
        clear_inputs();
        m_len[0] = 8'd3;
        run_txn(NUM_M'(1), 1'b0, 0, -1, 2, '0, g);
        m_len[1] = 8'd1;
        m_addr[1] = 32'h3000;
        run_txn(NUM_M'(2), 1'b0, 0, -1, -1, '0, g);
    endtask

    task automatic test_random();
        int g;
        logic [NUM_M-1:0] r;
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NUM_M; i++) begin
                m_addr[i]  = ADDR_W'($urandom);
                m_wdata[i] = DATA_W'($urandom);
                m_mask[i]  = 2'($urandom_range(0, 2));
                m_sign[i]  = 1'($urandom_range(0, 1));
                m_write[i] = ($urandom_range(0, 3) == 0);
                m_len[i]   = LEN_W'($urandom_range(0, 5));
            end
            r = NUM_M'($urandom_range(1, (1 << NUM_M) - 1));
            run_txn(r, 1'($urandom_range(0, 1)), $urandom_range(0, 2), -1, -1, '0, g);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst_read();
        test_arbitration();
        test_write();
        test_len_mismatch();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end
endmodule
